// File: rtl/frog_pkg.sv
// frog_pkg: direction indices, default timing constants and a sizing helper for the frog move conditioner
package frog_pkg;

    localparam int DIR_LEFT  = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_UP    = 2;
    localparam int DIR_RIGHT = 3;

    localparam int DEBOUNCE_CYCLES_DEF      = 250000;
    localparam int REPEAT_EN_DEF            = 1;
    localparam int REPEAT_DELAY_CYCLES_DEF  = 12500000;
    localparam int REPEAT_PERIOD_CYCLES_DEF = 5000000;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/switch_debounce_repeat.sv
// switch_debounce_repeat: one switch channel - synchroniser, counter debounce, press pulse, hold auto-repeat
module switch_debounce_repeat
    import frog_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_EN            = REPEAT_EN_DEF,
    parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEF,
    parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(imax(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES) + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_param_check
        $error("switch_debounce_repeat: all cycle parameters must be >= 1");
    end

    logic          s1, s2, stable, press, rpt, first;
    logic          db_done, hold_hit;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;

    // terminal-count decodes; a repeat never fires on the edge that flips the debounced state
    always_comb begin
        db_done  = (s2 != stable) && (db_cnt == DB_LAST);
        hold_hit = (REPEAT_EN != 0) && stable && !db_done && (hold_cnt == (first ? DLY_LAST : PER_LAST));
    end

    // two-flop synchroniser, then debounce: count consecutive disagreeing cycles, flip on the terminal one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            s1    <= sw;
            s2    <= s1;
            press <= db_done && s2;
            if (s2 == stable) begin
                db_cnt <= '0;
            end else if (db_done) begin
                stable <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // hold timer: restarts at the press, first interval is the delay, later ones the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            first    <= 1'b1;
            rpt      <= 1'b0;
        end else begin
            rpt <= hold_hit;
            if (!stable || db_done || REPEAT_EN == 0) begin
                hold_cnt <= '0;
                first    <= 1'b1;
            end else if (hold_hit) begin
                hold_cnt <= '0;
                first    <= 1'b0;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign pulse = press | rpt;

endmodule

// File: rtl/frog_move_conditioner.sv
// frog_move_conditioner: four debounced/auto-repeating switch channels with opposing-pair suppression
module frog_move_conditioner
    import frog_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_EN            = REPEAT_EN_DEF,
    parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEF,
    parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEF
) (
    input  logic i_Clk,
    input  logic reset_n,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    input  logic i_Switch_3,
    input  logic i_Switch_4,
    output logic o_Move_Left,
    output logic o_Move_Down,
    output logic o_Move_Up,
    output logic o_Move_Right
);

    logic [3:0] raw, pend, keep, move;
    logic       ud, lr;

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar g = 0; g < 4; g++) begin : g_ch
        switch_debounce_repeat #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_EN           (REPEAT_EN),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
        ) u_ch (
            .clk  (i_Clk),
            .rst_n(reset_n),
            .sw   (raw[g]),
            .pulse(pend[g])
        );
    end

    // same-cycle opposing pulses cancel each other; orthogonal ones pass untouched
    always_comb begin
        ud              = pend[DIR_UP] & pend[DIR_DOWN];
        lr              = pend[DIR_LEFT] & pend[DIR_RIGHT];
        keep            = pend;
        keep[DIR_UP]    = pend[DIR_UP] & ~ud;
        keep[DIR_DOWN]  = pend[DIR_DOWN] & ~ud;
        keep[DIR_LEFT]  = pend[DIR_LEFT] & ~lr;
        keep[DIR_RIGHT] = pend[DIR_RIGHT] & ~lr;
    end

    // output register
    always_ff @(posedge i_Clk or negedge reset_n) begin
        if (!reset_n) move <= '0;
        else          move <= keep;
    end

    assign o_Move_Left  = move[DIR_LEFT];
    assign o_Move_Down  = move[DIR_DOWN];
    assign o_Move_Up    = move[DIR_UP];
    assign o_Move_Right = move[DIR_RIGHT];

endmodule

// File: tb/tb_frog_move_conditioner.sv
// tb_frog_move_conditioner: directed vector table plus reset and no-repeat sequences
module tb_frog_move_conditioner;

    localparam logic [3:0] L  = 4'b0001;
    localparam logic [3:0] DN = 4'b0010;
    localparam logic [3:0] U  = 4'b0100;
    localparam logic [3:0] R  = 4'b1000;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] sw, sw2, mv, mv2;
    vec_t       vt [256];
    int         nv;
    int         tests;
    int         failed;

    always #5 clk = ~clk;

    frog_move_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(5)
    ) dut (
        .i_Clk(clk), .reset_n(reset_n),
        .i_Switch_1(sw[0]), .i_Switch_2(sw[1]), .i_Switch_3(sw[2]), .i_Switch_4(sw[3]),
        .o_Move_Left(mv[0]), .o_Move_Down(mv[1]), .o_Move_Up(mv[2]), .o_Move_Right(mv[3])
    );

    frog_move_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(5)
    ) dut_norep (
        .i_Clk(clk), .reset_n(reset_n),
        .i_Switch_1(sw2[0]), .i_Switch_2(sw2[1]), .i_Switch_3(sw2[2]), .i_Switch_4(sw2[3]),
        .o_Move_Left(mv2[0]), .o_Move_Down(mv2[1]), .o_Move_Up(mv2[2]), .o_Move_Right(mv2[3])
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic seg(input logic [3:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            vt[nv].sw  = s;
            vt[nv].exp = 4'b0000;
            nv++;
        end
    endtask

    task automatic mark(input int idx, input logic [3:0] e);
        vt[idx].exp = vt[idx].exp | e;
    endtask

    initial begin
        logic [19:0] pat;
        int          b, npulse;
        tests   = 0;
        failed  = 0;
        nv      = 0;
        pat     = 20'b0101_1101_1000_1011_1001;

        // clean press of up: sampled at edge 0, pulse after edge 6 only
        b = nv; seg(U, 8); seg(4'b0000, 20); mark(b + 6, U);
        // bounce on left with runs of 1-3 cycles, then steady high
        b = nv;
        for (int i = 0; i < 20; i++) seg(pat[i] ? L : 4'b0000, 1);
        seg(L, 8); seg(4'b0000, 20); mark(b + 26, L);
        // hold right 40 cycles: press then repeats every 10 then 5 until debounced release
        b = nv; seg(R, 40); seg(4'b0000, 25);
        mark(b + 6, R); mark(b + 16, R); mark(b + 21, R); mark(b + 26, R);
        mark(b + 31, R); mark(b + 36, R); mark(b + 41, R);
        // down and up together cancel
        seg(DN | U, 8); seg(4'b0000, 20);
        // up and right together both pass
        b = nv; seg(U | R, 8); seg(4'b0000, 20); mark(b + 6, U | R);

        reset_n = 1'b0;
        sw      = 4'b0000;
        sw2     = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_state", mv, 4'b0000);
        check("reset_state_norep", mv2, 4'b0000);
        reset_n = 1'b1;

        for (int i = 0; i < nv; i++) begin
            sw = vt[i].sw;
            @(negedge clk);
            check($sformatf("vec%0d", i), mv, vt[i].exp);
        end

        // reset asserted mid-debounce with the switch held, then released
        sw = U;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("pre_reset%0d", j), mv, 4'b0000);
        end
        reset_n = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1 check($sformatf("in_reset%0d", j), mv, 4'b0000);
            @(negedge clk);
        end
        reset_n = 1'b1;
        for (int j = 0; j < 26; j++) begin
            @(negedge clk);
            check($sformatf("post_reset%0d", j), mv, (j == 6) ? U : 4'b0000);
            if (j == 7) sw = 4'b0000;
        end

        // auto-repeat disabled: one pulse for a 40-cycle hold
        npulse = 0;
        for (int j = 0; j < 60; j++) begin
            sw2 = (j < 40) ? U : 4'b0000;
            @(negedge clk);
            if (mv2 != 4'b0000) npulse++;
            check($sformatf("norep%0d", j), mv2, (j == 6) ? U : 4'b0000);
        end
        tests++;
        if (npulse != 1) begin
            failed++;
            $display("FAIL norep_count: got %0d pulses want 1", npulse);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
